// File: rtl/qdr_port_arbiter.sv
// qdr_port_arbiter: shares one QDRII+ MIG user port between requesters with independent read/write round robin and in-order read tag return
module qdr_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 36,
    parameter int BURST_LEN  = 4,
    parameter int BW_WIDTH   = 4,
    parameter int TAG_DEPTH  = 16,
    localparam int UW = DATA_WIDTH * BURST_LEN,
    localparam int UB = BW_WIDTH * BURST_LEN,
    localparam int CW = $clog2(TAG_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             init_calib_complete,
    input  logic [NUM_PORTS-1:0]             wr_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_PORTS*UW-1:0]          wr_data,
    input  logic [NUM_PORTS*UB-1:0]          wr_bw_n,
    output logic [NUM_PORTS-1:0]             wr_ack,
    input  logic [NUM_PORTS-1:0]             rd_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_PORTS-1:0]             rd_ack,
    output logic [NUM_PORTS-1:0]             rd_valid,
    output logic [UW-1:0]                    rd_data,
    output logic                             app_wr_cmd,
    output logic [ADDR_WIDTH-1:0]            app_wr_addr,
    output logic [UW-1:0]                    app_wr_data,
    output logic [UB-1:0]                    app_wr_bw_n,
    output logic                             app_rd_cmd,
    output logic [ADDR_WIDTH-1:0]            app_rd_addr,
    input  logic                             app_rd_valid,
    input  logic [UW-1:0]                    app_rd_data,
    output logic [CW-1:0]                    rd_outstanding,
    output logic                             err_underflow
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = $clog2(TAG_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // first eligible port searching from last+1 with wrap; returns {hit, port}
    function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] elig, input logic [PW-1:0] last);
        logic [PW-1:0] p;
        logic [PW-1:0] win;
        logic          hit;
        p   = last;
        win = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            p = nxt(p);
            if (!hit && elig[p]) begin
                hit = 1'b1;
                win = p;
            end
        end
        return {hit, win};
    endfunction

    logic [ADDR_WIDTH-1:0] wa [NUM_PORTS];
    logic [UW-1:0]         wd [NUM_PORTS];
    logic [UB-1:0]         wb [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] ra [NUM_PORTS];

    logic [PW-1:0]         wr_last_q, wr_last_d, rd_last_q, rd_last_d;
    logic [NUM_PORTS-1:0]  wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
    logic                  app_wr_cmd_q, app_wr_cmd_d, app_rd_cmd_q, app_rd_cmd_d;
    logic [ADDR_WIDTH-1:0] app_wr_addr_q, app_wr_addr_d, app_rd_addr_q, app_rd_addr_d;
    logic [UW-1:0]         app_wr_data_q, app_wr_data_d;
    logic [UB-1:0]         app_wr_bw_n_q, app_wr_bw_n_d;
    logic [PW-1:0]         tag_mem_q [TAG_DEPTH];
    logic [PW-1:0]         tag_mem_d [TAG_DEPTH];
    logic [TW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]  rd_valid_q, rd_valid_d;
    logic [UW-1:0]         rd_data_q, rd_data_d;
    logic                  err_q, err_d;

    logic [NUM_PORTS-1:0]  wr_elig, rd_elig;
    logic                  wr_hit, rd_hit, push, pop;
    logic [PW-1:0]         wr_win, rd_win;

    // a port whose ack is high this cycle is excluded so a held request is not granted twice
    assign wr_elig = wr_req & ~wr_ack_q & {NUM_PORTS{init_calib_complete}};
    assign rd_elig = rd_req & ~rd_ack_q & {NUM_PORTS{init_calib_complete && (cnt_q < CW'(TAG_DEPTH))}};
    assign {wr_hit, wr_win} = rr_pick(wr_elig, wr_last_q);
    assign {rd_hit, rd_win} = rr_pick(rd_elig, rd_last_q);
    assign push = rd_hit;
    assign pop  = app_rd_valid && (cnt_q != '0);

    // split the flattened per-port request fields
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            wa[i] = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wd[i] = wr_data[i*UW +: UW];
            wb[i] = wr_bw_n[i*UB +: UB];
            ra[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // write channel: register the winning port's command; address/data hold when idle
    always_comb begin
        wr_last_d     = wr_hit ? wr_win : wr_last_q;
        wr_ack_d      = wr_hit ? (NUM_PORTS'(1) << wr_win) : '0;
        app_wr_cmd_d  = wr_hit;
        app_wr_addr_d = wr_hit ? wa[wr_win] : app_wr_addr_q;
        app_wr_data_d = wr_hit ? wd[wr_win] : app_wr_data_q;
        app_wr_bw_n_d = wr_hit ? wb[wr_win] : '1;
    end

    // read channel: issue command, push issuing port tag, pop tag on returning data
    always_comb begin
        rd_last_d     = rd_hit ? rd_win : rd_last_q;
        rd_ack_d      = rd_hit ? (NUM_PORTS'(1) << rd_win) : '0;
        app_rd_cmd_d  = rd_hit;
        app_rd_addr_d = rd_hit ? ra[rd_win] : app_rd_addr_q;
        tag_mem_d     = tag_mem_q;
        if (push)
            tag_mem_d[wptr_q] = rd_win;
        wptr_d        = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d        = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d         = cnt_q + CW'(push) - CW'(pop);
        rd_valid_d    = pop ? (NUM_PORTS'(1) << tag_mem_q[rptr_q]) : '0;
        rd_data_d     = pop ? app_rd_data : rd_data_q;
        err_d         = err_q || (app_rd_valid && (cnt_q == '0));
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_last_q     <= LAST;
            rd_last_q     <= LAST;
            wr_ack_q      <= '0;
            rd_ack_q      <= '0;
            app_wr_cmd_q  <= 1'b0;
            app_wr_addr_q <= '0;
            app_wr_data_q <= '0;
            app_wr_bw_n_q <= '1;
            app_rd_cmd_q  <= 1'b0;
            app_rd_addr_q <= '0;
            tag_mem_q     <= '{default: '0};
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            wr_last_q     <= wr_last_d;
            rd_last_q     <= rd_last_d;
            wr_ack_q      <= wr_ack_d;
            rd_ack_q      <= rd_ack_d;
            app_wr_cmd_q  <= app_wr_cmd_d;
            app_wr_addr_q <= app_wr_addr_d;
            app_wr_data_q <= app_wr_data_d;
            app_wr_bw_n_q <= app_wr_bw_n_d;
            app_rd_cmd_q  <= app_rd_cmd_d;
            app_rd_addr_q <= app_rd_addr_d;
            tag_mem_q     <= tag_mem_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            cnt_q         <= cnt_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            err_q         <= err_d;
        end
    end

    assign wr_ack         = wr_ack_q;
    assign rd_ack         = rd_ack_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign app_wr_cmd     = app_wr_cmd_q;
    assign app_wr_addr    = app_wr_addr_q;
    assign app_wr_data    = app_wr_data_q;
    assign app_wr_bw_n    = app_wr_bw_n_q;
    assign app_rd_cmd     = app_rd_cmd_q;
    assign app_rd_addr    = app_rd_addr_q;
    assign rd_outstanding = cnt_q;
    assign err_underflow  = err_q;
endmodule

// File: doc/qdr_port_arbiter.md
Name: qdr_port_arbiter

Overview:
- Shares the single QDRII+ MIG user interface (controller port 0) between NUM_PORTS requesters, such as the traffic generator and a DMA engine.
- QDRII+ has independent read and write command paths, so the block runs two independent round-robin arbiters: one for writes, one for reads.
- An in-order tag FIFO routes returning read data back to the issuing port.
- Sits between the requester logic and the MIG user interface, in the same clock domain (MIG user clock).

Parameters:
- NUM_PORTS, 2, number of requesters (2..4).
- ADDR_WIDTH, 18, user burst address width (matches qdriip_sa).
- DATA_WIDTH, 36, memory data width.
- BURST_LEN, 4, beats per user transfer. User data width UW = DATA_WIDTH*BURST_LEN = 144.
- BW_WIDTH, 4, byte-write enables per beat. User byte-enable width UB = BW_WIDTH*BURST_LEN = 16.
- TAG_DEPTH, 16, maximum outstanding reads (power of 2).

Ports:
- clk  in  1  user clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_calib_complete  in  1  from MIG; gates all grants.
- wr_req  in  NUM_PORTS  per-port write request, held until ack.
- wr_addr  in  NUM_PORTS*ADDR_WIDTH  flattened; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_data  in  NUM_PORTS*UW  flattened write data.
- wr_bw_n  in  NUM_PORTS*UB  flattened active-low byte enables.
- wr_ack  out  NUM_PORTS  one-cycle pulse, command issued.
- rd_req  in  NUM_PORTS  per-port read request, held until ack.
- rd_addr  in  NUM_PORTS*ADDR_WIDTH  flattened read address.
- rd_ack  out  NUM_PORTS  one-cycle pulse, command issued.
- rd_valid  out  NUM_PORTS  per-port read data valid.
- rd_data  out  UW  read data, shared by all ports.
- app_wr_cmd  out  1  to MIG.
- app_wr_addr  out  ADDR_WIDTH
- app_wr_data  out  UW
- app_wr_bw_n  out  UB
- app_rd_cmd  out  1
- app_rd_addr  out  ADDR_WIDTH
- app_rd_valid  in  1  from MIG.
- app_rd_data  in  UW
- rd_outstanding  out  log2(TAG_DEPTH)+1  current tag FIFO count.
- err_underflow  out  1  sticky; app_rd_valid arrived with no outstanding tag.

Behaviour:
- Reset values (asynchronous on rst_n=0):
  - All outputs 0, except app_wr_bw_n which resets to all-ones.
  - rd_outstanding = 0; err_underflow = 0.
  - Both round-robin pointers = NUM_PORTS-1, so port 0 has highest priority first.
  - Tag FIFO empty.
- Eligibility: port i is eligible in cycle t if its req=1, its ack=0 in cycle t, and init_calib_complete=1. Excluding ports with ack high prevents a held request from being granted twice. Each port therefore issues at most one command every 2 cycles; the aggregate rate is 1 per cycle per channel.
- Round robin: the search starts at last_grant+1 and wraps modulo NUM_PORTS. The first eligible port wins. last_grant updates only when a grant occurs.
- Write grant in cycle t:
  - At t+1: app_wr_cmd=1; app_wr_addr, app_wr_data and app_wr_bw_n are registered copies of the winning port's fields sampled at t; wr_ack[i]=1.
  - With no grant: app_wr_cmd=0, app_wr_bw_n all-ones, address/data hold their previous values.
- Read grant in cycle t: additionally requires rd_outstanding < TAG_DEPTH. This is conservative: a pop in the same cycle does not admit a grant at full. At t+1: app_rd_cmd=1, app_rd_addr registered, rd_ack[i]=1, and port id i is pushed into the tag FIFO.
- Read and write arbiters are fully independent. The same port may receive wr_ack and rd_ack in the same cycle.
- Read return:
  - On app_rd_valid=1 in cycle t: pop the head tag h.
  - At t+1: rd_valid[h]=1 (one-hot) and rd_data = app_rd_data sampled at t.
  - rd_data holds its value when rd_valid=0.
- Counting: rd_outstanding is +1 on push, -1 on pop, unchanged on a simultaneous push and pop.
- Underflow: app_rd_valid=1 while the FIFO is empty drops the data, raises no rd_valid, and sets err_underflow until reset.
- Calibration loss: if init_calib_complete falls mid-operation, no new grants are made. Commands already registered for the next cycle still issue, and outstanding reads still drain and deliver.
- Requester contract: the requester holds req and its fields stable until it samples ack=1. It may drop req or present a new request in the cycle after ack.

Test Plan:
1. Reset, then init_calib_complete=0 with wr_req=2'b11 for 20 cycles -> no app_wr_cmd and no wr_ack. Raise calib -> wr_ack[0] one cycle later, then wr_ack[1] next cycle, then port 0 again (alternating).
2. Port 1 writes addr 0x00123, data 144'hA5..A5, bw_n 16'h000F -> app_wr_cmd=1 with exactly those values one cycle after grant; app_wr_bw_n returns to 16'hFFFF afterwards.
3. Both ports hold rd_req, and the bench returns app_rd_valid 5 cycles after each app_rd_cmd with data = address -> rd_valid alternates [0],[1],[0],... and each port's rd_data equals its own requested address.
4. MIG read response withheld, port 0 issues reads continuously -> exactly 16 rd_acks, rd_outstanding=16, rd_req stays pending. One app_rd_valid -> count 15, next grant 1 cycle later.
5. Write and read requests from port 0 in the same cycle -> wr_ack[0] and rd_ack[0] in the same cycle; app_wr_cmd and app_rd_cmd both high.
6. app_rd_valid pulse with no outstanding read -> no rd_valid, err_underflow=1 and it stays 1. Assert rst_n=0 mid-burst -> all outputs at reset values immediately, rd_outstanding=0.
